// File: rtl/switch_io_port.sv
// Memory-mapped switch/confirm-button input port: synchronises the inputs, debounces the confirm button and serves six read modes.
// Define SWITCH_SNAPSHOT_EN to freeze the switch data at each confirm press instead of reading the live switches.
module switch_io_port #(
    parameter int          SW_WIDTH        = 16,
    parameter int          DATA_WIDTH      = 32,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FFF0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_ctrl,
    input  logic [31:0]           addr,
    input  logic [SW_WIDTH-1:0]   switch_input,
    input  logic                  confirm_btn,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  confirm_pending
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [3:0] OFF_FULL  = 4'h1;
    localparam logic [3:0] OFF_HI_SX = 4'h3;
    localparam logic [3:0] OFF_HI_ZX = 4'h5;
    localparam logic [3:0] OFF_CASE  = 4'h7;
    localparam logic [3:0] OFF_ACK   = 4'h9;
    localparam logic [3:0] OFF_LO_ZX = 4'hB;

    logic [SW_WIDTH-1:0]   r_sw_meta;
    logic [SW_WIDTH-1:0]   r_sw_s;
    logic                  r_btn_meta;
    logic                  r_btn_s;
    logic                  r_deb;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_read_data;

    logic                  w_btn_diff;
    logic                  w_deb_accept;
    logic                  w_deb_rise;
    logic [31:0]           w_offset;
    logic                  w_in_window;
    logic [SW_WIDTH-1:0]   w_src;
    logic [7:0]            w_hi8;
    logic [7:0]            w_lo8;
    logic                  w_rd_load;
    logic [DATA_WIDTH-1:0] w_rd_next;
    logic                  w_ack;

    // Two-flop synchronisers; only the second stage is ever consumed.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sw_meta  <= '0;
            r_sw_s     <= '0;
            r_btn_meta <= 1'b0;
            r_btn_s    <= 1'b0;
        end else begin
            r_sw_meta  <= switch_input;
            r_sw_s     <= r_sw_meta;
            r_btn_meta <= confirm_btn;
            r_btn_s    <= r_btn_meta;
        end
    end

    assign w_btn_diff   = (r_btn_s != r_deb);
    assign w_deb_accept = w_btn_diff && (r_cnt == CNT_LAST);
    assign w_deb_rise   = w_deb_accept && r_btn_s;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_deb <= 1'b0;
            r_cnt <= '0;
        end else if (!w_btn_diff || w_deb_accept) begin
            r_deb <= w_deb_accept ? r_btn_s : r_deb;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

`ifdef SWITCH_SNAPSHOT_EN
    logic [SW_WIDTH-1:0] r_snap;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_snap <= '0;
        end else if (w_deb_rise) begin
            r_snap <= r_sw_s;
        end
    end

    assign w_src = r_snap;
`else
    assign w_src = r_sw_s;
`endif

    assign w_hi8       = w_src[SW_WIDTH-1 -: 8];
    assign w_lo8       = w_src[7:0];
    assign w_offset    = addr - BASE_ADDR;
    assign w_in_window = sw_ctrl && (w_offset[31:4] == '0);

    // NOTE: defaults first so no path through the case leaves an output unassigned (no latch).
    always_comb begin
        w_rd_load = 1'b0;
        w_rd_next = '0;
        w_ack     = 1'b0;
        if (w_in_window) begin
            w_rd_load = 1'b1;
            unique case (w_offset[3:0])
                OFF_FULL:  w_rd_next = DATA_WIDTH'(w_src);
                OFF_HI_SX: w_rd_next = {{(DATA_WIDTH-8){w_hi8[7]}}, w_hi8};
                OFF_HI_ZX: w_rd_next = DATA_WIDTH'(w_hi8);
                OFF_CASE:  w_rd_next = DATA_WIDTH'(w_src[2:0]);
                OFF_ACK: begin
                    w_rd_next = DATA_WIDTH'(r_pending);
                    w_ack     = 1'b1;
                end
                OFF_LO_ZX: w_rd_next = DATA_WIDTH'(w_lo8);
                default:   w_rd_load = 1'b0;
            endcase
        end
    end

    // A confirm edge landing on the acknowledge read keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pending   <= 1'b0;
            r_read_data <= '0;
        end else begin
            if (w_deb_rise) begin
                r_pending <= 1'b1;
            end else if (w_ack) begin
                r_pending <= 1'b0;
            end
            if (w_rd_load) begin
                r_read_data <= w_rd_next;
            end
        end
    end

    assign read_data       = r_read_data;
    assign confirm_pending = r_pending;

endmodule

// File: tb/tb_switch_io_port.sv
// Self-checking bench for switch_io_port: directed scenarios followed by randomized traffic against a cycle-level behavioural model.
module tb_switch_io_port;

    localparam int          D    = 4;
    localparam logic [31:0] BASE = 32'hFFFF_FFF0;

    logic        clk = 1'b0;
    logic        rst;
    logic        sw_ctrl;
    logic [31:0] addr;
    logic [15:0] switch_input;
    logic        confirm_btn;
    logic [31:0] read_data;
    logic        confirm_pending;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: pins sampled on earlier edges (front = value the second stage holds now)
    logic [16:0] m_hist[$];
    logic        m_deb;
    int          m_run;
    logic        m_pend;
    logic [15:0] m_snap;
    logic [31:0] m_rd;

    switch_io_port #(
        .SW_WIDTH       (16),
        .DATA_WIDTH     (32),
        .DEBOUNCE_CYCLES(D),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sw_ctrl        (sw_ctrl),
        .addr           (addr),
        .switch_input   (switch_input),
        .confirm_btn    (confirm_btn),
        .read_data      (read_data),
        .confirm_pending(confirm_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_mode(input logic [3:0] off);
        return off inside {4'h1, 4'h3, 4'h5, 4'h7, 4'h9, 4'hB};
    endfunction

    function automatic logic [31:0] mode_value(input logic [3:0] off, input logic [15:0] src);
        byte b;
        case (off)
            4'h1:    return 32'(src);
            4'h3:    begin b = byte'(src / 256); return 32'(int'(b)); end
            4'h5:    return 32'(src / 256);
            4'h7:    return 32'(src % 8);
            4'hB:    return 32'(src % 256);
            default: return 32'h0;
        endcase
    endfunction

    function automatic void model_reset();
        m_hist.delete();
        m_hist.push_back(17'h0);
        m_hist.push_back(17'h0);
        m_deb  = 1'b0;
        m_run  = 0;
        m_pend = 1'b0;
        m_snap = '0;
        m_rd   = '0;
    endfunction

    // Advance the model by one edge from the applied inputs, clock the DUT, compare outputs.
    task automatic tick();
        logic [16:0] pre;
        logic [15:0] src;
        logic [31:0] off;
        logic        rise;
        if (!rst) begin
            model_reset();
        end else begin
            pre  = m_hist[0];
            off  = addr - BASE;
            rise = 1'b0;
`ifdef SWITCH_SNAPSHOT_EN
            src = m_snap;
`else
            src = pre[15:0];
`endif
            if (pre[16] != m_deb) begin
                m_run++;
                if (m_run == D) begin
                    m_deb = pre[16];
                    m_run = 0;
                    rise  = m_deb;
                end
            end else begin
                m_run = 0;
            end
            if (sw_ctrl && off < 16 && is_mode(off[3:0]))
                m_rd = (off == 9) ? 32'(m_pend) : mode_value(off[3:0], src);
            if (rise) begin
                m_pend = 1'b1;
                m_snap = pre[15:0];
            end else if (sw_ctrl && off == 9) begin
                m_pend = 1'b0;
            end
            void'(m_hist.pop_front());
            m_hist.push_back({confirm_btn, switch_input});
        end
        @(posedge clk);
        #1;
        check("cyc_rd", read_data, m_rd);
        check("cyc_pend", 32'(confirm_pending), 32'(m_pend));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [3:0] off);
        sw_ctrl = 1'b1;
        addr    = BASE + 32'(off);
        tick();
        sw_ctrl = 1'b0;
        addr    = 32'h0;
    endtask

    initial begin
        int btn_left;
        rst          = 1'b0;
        sw_ctrl      = 1'b0;
        addr         = 32'h0;
        switch_input = 16'hFFFF;
        confirm_btn  = 1'b1;
        model_reset();

        // Reset held with all inputs high
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rd", read_data, 32'h0);
            check("rst_pend", 32'(confirm_pending), 32'h0);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_pend0", 32'(confirm_pending), 32'h0);
        end
        tick();
        check("post_rst_pend1", 32'(confirm_pending), 32'h1);
        rd(4'h9);
        check("post_rst_ack", read_data, 32'h1);
        confirm_btn = 1'b0;
        idle(8);

        // Glitch shorter than D, then a real press
        confirm_btn = 1'b1;
        idle(3);
        confirm_btn = 1'b0;
        idle(8);
        check("glitch_pend", 32'(confirm_pending), 32'h0);
        confirm_btn = 1'b1;
        idle(5);
        check("deb_edge5", 32'(confirm_pending), 32'h0);
        tick();
        check("deb_edge6", 32'(confirm_pending), 32'h1);

        // Acknowledge
        rd(4'h9);
        check("ack_rd1", read_data, 32'h1);
        check("ack_pend", 32'(confirm_pending), 32'h0);
        rd(4'h9);
        check("ack_rd2", read_data, 32'h0);
        confirm_btn = 1'b0;
        idle(8);

        // Acknowledge read on the same edge the debounced level rises
        rd(4'hB);
        confirm_btn = 1'b1;
        idle(5);
        rd(4'h9);
        check("coll_rd", read_data, 32'h0);
        check("coll_pend", 32'(confirm_pending), 32'h1);
        rd(4'h9);
        confirm_btn = 1'b0;
        idle(8);

        // Snapshot versus live data
        switch_input = 16'h0012;
        idle(3);
        confirm_btn = 1'b1;
        idle(6);
        switch_input = 16'h00FF;
        idle(3);
        rd(4'h1);
`ifdef SWITCH_SNAPSHOT_EN
        check("snap_rd", read_data, 32'h0000_0012);
`else
        check("snap_rd", read_data, 32'h0000_00FF);
`endif
        rd(4'h9);
        confirm_btn = 1'b0;
        idle(8);

        // Read modes
        switch_input = 16'hA5C3;
        idle(3);
`ifdef SWITCH_SNAPSHOT_EN
        rd(4'h1); rd(4'h3); rd(4'h5); rd(4'h7); rd(4'hB); rd(4'h2);
`else
        rd(4'h1); check("mode_full", read_data, 32'h0000_A5C3);
        rd(4'h3); check("mode_hi_sx", read_data, 32'hFFFF_FFA5);
        rd(4'h5); check("mode_hi_zx", read_data, 32'h0000_00A5);
        rd(4'h7); check("mode_case", read_data, 32'h0000_0003);
        rd(4'hB); check("mode_lo_zx", read_data, 32'h0000_00C3);
        rd(4'h2); check("mode_hold", read_data, 32'h0000_00C3);
`endif

        // Randomized traffic against the model
        btn_left = 0;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 7) == 0) switch_input = 16'($urandom);
            if (btn_left == 0) begin
                confirm_btn = 1'($urandom_range(0, 1));
                btn_left    = $urandom_range(1, 10);
            end
            btn_left--;
            sw_ctrl = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else                           addr = BASE + 32'($urandom_range(0, 15));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/switch_io_port.md
Name: switch_io_port

Overview:
Memory-mapped switch/button input peripheral for the CPU I/O space; parametrised successor to the fixed 16-bit switch reader.
- Synchronises the switch bank and the confirm button.
- Debounces the confirm button and latches a sticky "confirm pending" flag that the CPU polls and clears by reading.
- Returns the switch data in several extraction/extension modes, selected by address.
- Sits beside the LED/seg I/O blocks on the data-memory bus and drives the I/O read-data mux.

Parameters:
SW_WIDTH, 16, number of switch inputs; legal range 8..DATA_WIDTH.
DATA_WIDTH, 32, width of read_data.
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a confirm level change; must be >= 2.
BASE_ADDR, 32'hFFFF_FFF0, base of the 16-byte register window.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
sw_ctrl  input  1  I/O read strobe for this block, from the decoder
addr  input  32  byte address of the access
switch_input  input  SW_WIDTH  raw switch pins, asynchronous
confirm_btn  input  1  raw confirm button, asynchronous, active-high
read_data  output  DATA_WIDTH  registered read result
confirm_pending  output  1  sticky flag: debounced confirm rising edge not yet acknowledged

Behaviour:
- Reset (rst==0 at posedge clk):
  - read_data=0, confirm_pending=0.
  - Both synchroniser stages cleared; debounced level=0; debounce counter=0; snapshot=0.
  - Reset asserted mid-debounce or mid-read discards all progress.
- Synchronisers: two flops on every switch_input bit and on confirm_btn. Only the second-stage values (sw_s, btn_s) are used.
- Debounce of btn_s:
  - If btn_s == deb: counter clears to 0.
  - Else, if counter < DEBOUNCE_CYCLES-1: counter increments.
  - Else: deb <= btn_s and counter clears to 0.
  - Result: a pin change held for D cycles is accepted on the (D+2)th rising edge after the pin changes. A glitch shorter than D cycles never changes deb.
- confirm_pending:
  - Sets on the same edge deb goes 0->1.
  - Clears on a read of offset 0x9.
  - If a set and a clear occur on the same edge, set wins (stays 1).
  - deb going 1->0 has no effect.
- Read decode, on an edge with sw_ctrl==1 and addr==BASE_ADDR+offset; hi8 = data source[SW_WIDTH-1 -: 8], lo8 = data source[7:0]:
  - 0x1: data source zero-extended to DATA_WIDTH.
  - 0x3: hi8 sign-extended.
  - 0x5: hi8 zero-extended.
  - 0x7: data source[2:0] zero-extended (test-case number).
  - 0x9: {0…, confirm_pending} using its pre-edge value; clears the flag on this edge.
  - 0xB: lo8 zero-extended.
- Any other offset, any address outside the window, or sw_ctrl==0: read_data holds its previous value.
- Latency: read_data is valid on the edge after the strobe edge (1-cycle registered read). Back-to-back strobes are allowed, one result per cycle.
- Data source is sw_s, unless the snapshot option below is enabled.

Optional Feature:
Macro SWITCH_SNAPSHOT_EN.
- Defined:
  - An SW_WIDTH snapshot register loads sw_s on the same edge confirm_pending sets.
  - All switch modes (0x1, 0x3, 0x5, 0x7, 0xB) read the snapshot, so data is frozen at confirmation.
  - Snapshot resets to 0.
- Undefined: no snapshot register; all modes read live sw_s.

Test Plan:
1. Reset: rst=0 for 3 cycles with switch_input=16'hFFFF, confirm_btn=1 -> read_data=0 and confirm_pending=0 throughout; after release, no pending until the debounce completes.
2. Modes: DEBOUNCE_CYCLES=4, switch_input=16'hA5C3, settle 3 cycles, then strobe each offset -> the cycle after each strobe:
   - 0x1 -> 32'h0000A5C3
   - 0x3 -> 32'hFFFFFFA5
   - 0x5 -> 32'h000000A5
   - 0x7 -> 32'h00000003
   - 0xB -> 32'h000000C3
   Then addr=BASE_ADDR+0x2 -> read_data unchanged (32'h000000C3).
3. Debounce: D=4, confirm_btn high for 3 cycles then low -> confirm_pending stays 0. confirm_btn held high -> confirm_pending=1 after exactly the 6th rising edge from the pin change.
4. Acknowledge: with pending=1, strobe 0x9 -> read_data=1 and pending=0 next cycle; second 0x9 read -> read_data=0.
5. Collision: align a 0x9 read with the edge deb rises (D=4) -> read_data=0, confirm_pending=1 afterwards.
6. With SWITCH_SNAPSHOT_EN: switches=16'h0012, confirm, then switches=16'h00FF, read 0x1 -> 32'h00000012. Without the macro, the same sequence -> 32'h000000FF.
